// File: rtl/axis_post_restore.sv
// Purpose : pairs each core result with its queued input sign and rebuilds f(x) from
//           the function's symmetry (even / odd / point-symmetric about OFFSET/2).
// Latency : 1 cycle from result accept to out_valid; a sign needs one cycle in the FIFO.
// Backpressure: res_ready drops while the sign FIFO is empty or the output is held.
// Ports   : clk, rst_n (sync, active-low); sign_valid/sign_in/sign_ready from the pre
//           stage; res_valid/res_in/res_ready from the core; out_valid/out_data/out_ready
//           downstream; level = signs queued; sat_flag = sticky saturation indicator.
module axis_post_restore #(
   parameter int M         = 4,
   parameter int N         = 8,
   parameter int FUNC_TYPE = 0,
   parameter int OFFSET    = 256,
   parameter int DEPTH     = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sign_valid,
   input  logic                       sign_in,
   output logic                       sign_ready,
   input  logic                       res_valid,
   input  logic [M+N-1:0]             res_in,
   output logic                       res_ready,
   output logic                       out_valid,
   output logic [M+N-1:0]             out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       sat_flag
);
   localparam int W  = M + N;
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [W-1:0] OFF_W = W'(OFFSET);

   logic [DEPTH-1:0] sign_mem;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             empty;
   logic             push;
   logic             fire;
   logic             head_sign;

   logic signed [W:0] res_ext;
   logic signed [W:0] off_ext;
   logic signed [W:0] wide;
   logic [W-1:0]      sat_val;
   logic              clamp;

   assign full       = (level == LW'(DEPTH));
   assign empty      = (level == '0);
   // Handshakes are held low during reset so nothing is accepted into a clearing FIFO.
   assign sign_ready = rst_n && !full;
   assign res_ready  = rst_n && !empty && (!out_valid || out_ready);
   assign push       = sign_valid && sign_ready;
   assign fire       = res_valid && res_ready;
   assign head_sign  = sign_mem[rd_ptr];

   // Reconstruction is done one bit wider so -min and OFFSET-x never wrap before the clamp.
   always_comb begin
      res_ext = {res_in[W-1], res_in};
      off_ext = {OFF_W[W-1], OFF_W};
      wide    = res_ext;
      if (head_sign) begin
         case (FUNC_TYPE)
            1:       wide = -res_ext;
            2:       wide = off_ext - res_ext;
            default: wide = res_ext;
         endcase
      end
      // Out of W-bit range exactly when the two top bits disagree.
      clamp = (wide[W] != wide[W-1]);
      if (clamp) begin
         sat_val = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
         sat_val = wide[W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         sat_flag  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (fire) rd_ptr <= rd_ptr + AW'(1);
         case ({push, fire})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: ;
         endcase
         if (fire) begin
            out_data  <= sat_val;
            out_valid <= 1'b1;
            if (clamp) sat_flag <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Sign storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (push) sign_mem[wr_ptr] <= sign_in;
   end
endmodule

// File: tb/tb_axis_post_restore.sv
`timescale 1ns/1ps
module tb_axis_post_restore;
   localparam int W     = 12;
   localparam int DEPTH = 8;
   localparam int LW    = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n      = 1'b0;
   logic         sign_valid = 1'b0;
   logic         sign_in    = 1'b0;
   logic         res_valid  = 1'b0;
   logic [W-1:0] res_in     = '0;
   logic         out_ready  = 1'b1;

   logic         srdy [3];
   logic         rrdy [3];
   logic         ov   [3];
   logic         sf   [3];
   logic [W-1:0] od   [3];
   logic [LW-1:0] lv  [3];

   // One instance per symmetry type, all driven by the same stimulus.
   for (genvar k = 0; k < 3; k++) begin : g_dut
      axis_post_restore #(.M(4), .N(8), .FUNC_TYPE(k), .OFFSET(256), .DEPTH(DEPTH)) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .sign_valid (sign_valid),
         .sign_in    (sign_in),
         .sign_ready (srdy[k]),
         .res_valid  (res_valid),
         .res_in     (res_in),
         .res_ready  (rrdy[k]),
         .out_valid  (ov[k]),
         .out_data   (od[k]),
         .out_ready  (out_ready),
         .level      (lv[k]),
         .sat_flag   (sf[k])
      );
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit           q[$];
   bit           m_ov;
   logic [W-1:0] m_od [3];
   bit           m_sat[3];
   bit           armed = 1'b0;

   function automatic int recon(int t, bit s, logic [W-1:0] r);
      int x;
      x = $signed(r);
      if (s && t == 1) return -x;
      if (s && t == 2) return 256 - x;
      return x;
   endfunction

   always @(posedge clk) begin : model
      bit s;
      bit acc_sign;
      bit acc_res;
      int v;
      if (!rst_n) begin
         q.delete();
         m_ov = 1'b0;
         for (int k = 0; k < 3; k++) begin
            m_od[k]  = '0;
            m_sat[k] = 1'b0;
         end
         armed = 1'b1;
      end else if (armed) begin
         acc_sign = sign_valid && (q.size() < DEPTH);
         acc_res  = res_valid && (q.size() > 0) && (!m_ov || out_ready);
         if (acc_res) begin
            s = q.pop_front();
            for (int k = 0; k < 3; k++) begin
               v = recon(k, s, res_in);
               if (v > 2047) begin
                  v = 2047;
                  m_sat[k] = 1'b1;
               end else if (v < -2048) begin
                  v = -2048;
                  m_sat[k] = 1'b1;
               end
               m_od[k] = v[W-1:0];
            end
            m_ov = 1'b1;
         end else if (out_ready) begin
            m_ov = 1'b0;
         end
         if (acc_sign) q.push_back(sign_in);
      end
   end

   // Compare process: every cycle once reset has been seen.
   always @(negedge clk) begin
      if (armed) begin
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("sign_ready[%0d]", k), srdy[k], rst_n && (q.size() < DEPTH));
            chk($sformatf("res_ready[%0d]", k), rrdy[k],
                rst_n && (q.size() > 0) && (!m_ov || out_ready));
            chk($sformatf("out_valid[%0d]", k), ov[k], m_ov);
            chk($sformatf("out_data[%0d]", k), od[k], m_od[k]);
            chk($sformatf("level[%0d]", k), lv[k], q.size());
            chk($sformatf("sat_flag[%0d]", k), sf[k], m_sat[k]);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input bit sv, input bit si, input bit rv,
                        input logic [W-1:0] ri, input bit ordy);
      sign_valid = sv;
      sign_in    = si;
      res_valid  = rv;
      res_in     = ri;
      out_ready  = ordy;
      tick();
   endtask

   task automatic do_reset();
      sign_valid = 1'b0;
      res_valid  = 1'b0;
      out_ready  = 1'b1;
      rst_n      = 1'b0;
      tick();
      rst_n      = 1'b1;
   endtask

   initial begin : stim
      logic [7:0]   pat;
      logic [W-1:0] held;
      int           budget;
      pat = 8'b1011_0010;

      // Reset state
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst level", lv[0], 0);
      chk("rst out_valid", ov[1], 0);
      chk("rst out_data", od[2], 0);
      chk("rst sign_ready", srdy[0], 0);
      chk("rst res_ready", rrdy[0], 0);
      rst_n = 1'b1;

      // T1: odd negation, latency 1
      drive(1, 1, 0, 12'h000, 1);
      chk("T1 no output before accept", ov[1], 0);
      drive(0, 0, 1, 12'h100, 1);
      chk("T1 out_valid", ov[1], 1);
      chk("T1 odd neg", od[1], 12'hF00);
      chk("T1 even", od[0], 12'h100);
      chk("T1 point", od[2], 12'h000);
      drive(1, 0, 0, 12'h000, 1);
      drive(0, 0, 1, 12'h100, 1);
      chk("T1 odd pos", od[1], 12'h100);

      // T2: negate minimum saturates, sticky flag
      drive(1, 1, 0, 12'h000, 1);
      drive(0, 0, 1, 12'h800, 1);
      chk("T2 odd sat", od[1], 12'h7FF);
      chk("T2 sat_flag", sf[1], 1);
      chk("T2 even no sat", sf[0], 0);
      chk("T2 point sat", od[2], 12'h7FF);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 12'h000, 1);
      chk("T2 sat sticky", sf[1], 1);
      do_reset();
      chk("T2 sat cleared", sf[1], 0);

      // T3: point symmetry about 0.5
      drive(1, 1, 0, 12'h000, 1);
      drive(0, 0, 1, 12'h0C0, 1);
      chk("T3 point neg", od[2], 12'h040);
      chk("T3 odd neg", od[1], 12'hF40);
      drive(1, 0, 0, 12'h000, 1);
      drive(0, 0, 1, 12'h0C0, 1);
      chk("T3 point pos", od[2], 12'h0C0);
      chk("T3 sat_flag", sf[2], 0);

      // T4: fill the FIFO
      do_reset();
      for (int i = 0; i < 8; i++) drive(1, pat[i], 0, 12'h000, 1);
      chk("T4 full level", lv[0], 8);
      chk("T4 full sign_ready", srdy[0], 0);
      drive(1, 1, 0, 12'h000, 1);
      chk("T4 9th held", lv[0], 8);
      drive(1, 1, 1, 12'h010, 1);
      chk("T4 pop level", lv[0], 7);
      chk("T4 pop sign_ready", srdy[0], 1);
      drive(1, 1, 0, 12'h000, 1);
      chk("T4 9th accepted", lv[0], 8);

      // T5: output stall
      drive(0, 0, 1, 12'h020, 1);
      chk("T5 valid", ov[0], 1);
      out_ready = 1'b0;
      res_valid = 1'b1;
      res_in    = 12'h030;
      #1;
      held = od[2];
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("T5 res_ready stalled", rrdy[0], 0);
         chk("T5 out_data held", od[2], held);
         chk("T5 out_valid held", ov[0], 1);
      end
      out_ready = 1'b1;
      tick();
      chk("T5 accepted", od[0], 12'h030);
      budget = 50;
      res_valid = 1'b1;
      while (lv[0] != 0 && budget > 0) begin
         res_in = W'($urandom);
         tick();
         budget--;
      end
      chk("T5 drain in budget", budget > 0, 1);
      res_valid = 1'b0;
      tick();

      // T6: reset mid-operation
      for (int i = 0; i < 3; i++) drive(1, 1, 0, 12'h000, 1);
      chk("T6 queued", lv[0], 3);
      do_reset();
      chk("T6 level", lv[0], 0);
      chk("T6 out_valid", ov[0], 0);
      chk("T6 res_ready", rrdy[0], 0);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 12'h055, 1);
         chk("T6 stalled", ov[0], 0);
      end
      drive(1, 1, 1, 12'h055, 1);
      chk("T6 no bypass", ov[1], 0);
      drive(0, 0, 1, 12'h055, 1);
      chk("T6 fired", ov[1], 1);
      chk("T6 value", od[1], 12'hFAB);

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         int ph;
         ph = c / 500;
         rst_n      = ($urandom_range(0, 599) != 0);
         sign_valid = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 70 : 35));
         sign_in    = $urandom_range(0, 1);
         res_valid  = ($urandom_range(0, 99) < ((ph % 3 == 0) ? 40 : 75));
         out_ready  = ($urandom_range(0, 99) < ((ph == 4) ? 30 : 75));
         case ($urandom_range(0, 7))
            0:       res_in = 12'h800;
            1:       res_in = 12'h7FF;
            2:       res_in = 12'hF00;
            default: res_in = W'($urandom);
         endcase
         tick();
      end
      rst_n = 1'b1;
      sign_valid = 1'b0;
      res_valid  = 1'b0;
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
